req_arbiter4: RTL and testbench
===============================

Name: req_arbiter4

Overview:
- Upstream stage of the 4:2 enable-gated encoder.
- Captures rising edges on four request lines and queues them as pending.
- Issues pending requests one at a time as registered one-hot lines a/b/c/d plus en, using round-robin priority.
- Holds each grant until the consumer acknowledges it or a timeout expires.

Parameters:
HOLD_MAX, 8, maximum cycles a grant is held without ack before forced release (legal range 2..255)
CNT_W, 8, width of hold counter; must satisfy 2**CNT_W > HOLD_MAX

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  4  level request lines; bit0..bit3 map to a..d
ack  input  1  consumer accepted current grant; sampled only in GRANT
a  output  1  one-hot grant bit0 to encoder input a
b  output  1  one-hot grant bit1 to encoder input b
c  output  1  one-hot grant bit2 to encoder input c
d  output  1  one-hot grant bit3 to encoder input d
en  output  1  grant valid, to encoder en
pending  output  4  queued-not-yet-served requests
timeout  output  1  one-cycle pulse when a grant is dropped by timeout

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on rst. All outputs are registered.
- Reset values (rst high at a clock edge):
  - a, b, c, d, en, timeout = 0; pending = 0.
  - req_q = 0; hold counter = 0; state = IDLE.
  - Last-grant pointer = 3, so bit0 (a) has first priority.
- Reset mid-grant drops the grant immediately; no timeout pulse.
- Edge capture:
  - req_q registers req every cycle.
  - rise = req & ~req_q.
  - pending_next = (pending & ~clr) | rise.
  - Set wins over clear on the same bit in the same cycle.
  - A level held high produces exactly one pending entry.
- Pick function: first set bit of pending scanning from (ptr+1) mod 4 upward with wrap. Result is one-hot, or zero if pending == 0.
- FSM, states IDLE, GRANT, RELEASE:
  - IDLE:
    - If pending != 0: load {d,c,b,a} = pick, en = 1, counter = 0, go to GRANT.
    - Otherwise stay in IDLE with outputs 0.
    - Pending uses the registered value, so a rise seen at edge k grants at edge k+1, and en is visible in cycle k+1.
  - GRANT:
    - Grant lines and en hold steady.
    - ack = 1: clr = granted bit, ptr = granted index, grant lines and en go to 0, go to RELEASE.
    - ack = 0 and counter == HOLD_MAX-1: same as ack, plus timeout = 1 for one cycle.
    - Otherwise counter increments.
  - RELEASE:
    - One idle cycle with en = 0, guaranteeing an en low gap between grants.
    - Then go to IDLE.
- Throughput: a back-to-back grant with immediate ack takes 3 cycles: GRANT, RELEASE, IDLE→GRANT.
- Invariants:
  - en = 1 iff exactly one of a..d is 1.
  - a..d are all 0 when en = 0.
- ack outside GRANT is ignored.
- A new rise on the bit currently granted, arriving while it is being acked, leaves that bit pending and serves it again later.
- All four pending at once: served in order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
- Counter width: compare uses CNT_W bits; counter never exceeds HOLD_MAX-1.

Decomposition:
- Package req_arbiter_pkg holds:
  - state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - NUM_REQ = 4;
  - index constants IDX_A..IDX_D.
- Sub-module rr_pick4, purely combinational: pending[3:0] plus ptr[1:0] in, onehot[3:0] plus idx[1:0] out. It is the natural unit to test exhaustively (64 cases).

Test Plan:
- Reset then single request:
  - Stimulus: rst 2 cycles, then req = 4'b1000 raised at edge k; ack at the first GRANT cycle.
  - Response: pending = 1000 after edge k; d = 1, en = 1 after k+1; after ack, en = 0 and pending = 0000.
- Round-robin order:
  - Stimulus: from reset, req = 4'b1111 in one cycle; ack every GRANT cycle.
  - Response: grants a, b, c, d in that order; each en pulse is 1 cycle wide with a 2-cycle gap.
- Timeout:
  - Stimulus: HOLD_MAX = 4, req = 4'b0100, ack never asserted.
  - Response: c = 1 for exactly 4 cycles; timeout pulses 1 cycle; pending[2] clears.
- Held level:
  - Stimulus: req[0] held high for 20 cycles, acked.
  - Response: exactly one grant of a; pending stays 0 afterwards.
- Set-over-clear:
  - Stimulus: req[1] rises, is granted; req[1] drops and rises again in the same cycle as ack.
  - Response: pending[1] remains 1; b is granted a second time.
- Reset mid-grant:
  - Stimulus: assert rst while en = 1 with pending = 1010.
  - Response: next cycle all outputs 0, pending = 0000; the following request of 1111 grants a first.

Source files
------------

// File: rtl/req_arbiter_pkg.sv
// rtl/req_arbiter_pkg.sv - shared types and constants for the 4-way request arbiter
package req_arbiter_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin pick of the first pending bit after the last grant
module rr_pick4
  import req_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [1:0]         idx
);

  logic [1:0] cand;
  logic       found;

  // Scan from ptr+1 upward with wrap; the 2-bit add gives the mod-4 wrap for free.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + 2'(i + 1);
      if (!found && pending[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/req_arbiter4.sv
// rtl/req_arbiter4.sv - edge-captured, round-robin, ack-or-timeout grant issuer
module req_arbiter4
  import req_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 ack,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 en,
  output logic [NUM_REQ-1:0]   pending,
  output logic                 timeout
);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [NUM_REQ-1:0] pick_oh;
  logic [1:0]         pick_idx;
  logic [1:0]         ptr, ptr_n;
  logic [1:0]         gidx, gidx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               en_n;
  logic               timeout_n;

  assign rise = req & ~req_q;

  assign a = grant[IDX_A];
  assign b = grant[IDX_B];
  assign c = grant[IDX_C];
  assign d = grant[IDX_D];

  rr_pick4 u_pick (
    .pending (pending),
    .ptr     (ptr),
    .onehot  (pick_oh),
    .idx     (pick_idx)
  );

  // State, grant and edge-capture registers; a new rise wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      pending <= '0;
      grant   <= '0;
      en      <= 1'b0;
      timeout <= 1'b0;
      ptr     <= IDX_D;
      gidx    <= IDX_A;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      req_q   <= req;
      pending <= (pending & ~clr) | rise;
      grant   <= grant_n;
      en      <= en_n;
      timeout <= timeout_n;
      ptr     <= ptr_n;
      gidx    <= gidx_n;
      cnt     <= cnt_n;
    end
  end

  // Next-state and next-output logic; ack only matters while a grant is held.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    en_n      = en;
    gidx_n    = gidx;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          grant_n = pick_oh;
          gidx_n  = pick_idx;
          en_n    = 1'b1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (ack || (cnt == CNT_W'(HOLD_MAX - 1))) begin
          clr       = grant;
          ptr_n     = gidx;
          grant_n   = '0;
          en_n      = 1'b0;
          timeout_n = ~ack;
          state_n   = RELEASE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        en_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_req_arbiter4.sv
// tb/tb_req_arbiter4.sv - self-checking bench for req_arbiter4 and rr_pick4
module tb_req_arbiter4;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       a, b, c, d, en, timeout;
  logic [3:0] pending;

  logic [3:0] pk_pend, pk_oh;
  logic [1:0] pk_ptr, pk_idx;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int         m_g;
  int         m_last;
  int         m_hold;
  int         m_gap;
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic       m_tmo;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       ak;
    logic [3:0] grant;
    logic       en;
    logic [3:0] pend;
    logic       tmo;
  } vec_t;

  vec_t vecs[21];

  always #5 clk = ~clk;

  req_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .en      (en),
    .pending (pending),
    .timeout (timeout)
  );

  rr_pick4 u_pk (
    .pending (pk_pend),
    .ptr     (pk_ptr),
    .onehot  (pk_oh),
    .idx     (pk_idx)
  );

  function automatic int mpick(input logic [3:0] p, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    logic [3:0] g;
    g = '0;
    if (m_g >= 0) g[m_g] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of the arbiter described in terms of grant index, hold age and gap cycles.
  task automatic model_step(input logic r, input logic [3:0] rq, input logic ak);
    int         clr;
    logic [3:0] rise;
    rise  = rq & ~m_prev;
    clr   = -1;
    m_tmo = 1'b0;
    if (r) begin
      m_g    = -1;
      m_last = 3;
      m_hold = 0;
      m_gap  = 0;
      m_pend = '0;
      m_prev = '0;
    end else begin
      if (m_g >= 0) begin
        if (ak || m_hold == HOLD_MAX) begin
          m_tmo  = ~ak;
          clr    = m_g;
          m_last = m_g;
          m_g    = -1;
          m_gap  = 1;
        end else begin
          m_hold++;
        end
      end else if (m_gap > 0) begin
        m_gap = 0;
      end else begin
        m_g = mpick(m_pend, m_last);
        if (m_g >= 0) m_hold = 1;
      end
      for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] && i != clr) || rise[i];
      m_prev = rq;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic ak);
    rst = r;
    req = rq;
    ack = ak;
    @(posedge clk);
    model_step(r, rq, ak);
    #1;
    check("model", {timeout, en, pending, d, c, b, a}, {m_tmo, (m_g >= 0), m_pend, m_grant()});
    check("onehot_inv", {en, ($countones({d, c, b, a}) == 1)}, {en, en});
  endtask

  initial begin : main
    int ccnt, tcnt, gcnt;

    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    m_g = -1; m_last = 3; m_hold = 0; m_gap = 0; m_pend = '0; m_prev = '0; m_tmo = 1'b0;

    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0};
    vecs[3]  = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0};
    vecs[4]  = '{1'b0, 4'b1000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b1111, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'b1111, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1110, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1110, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 4'b1110, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1100, 1'b0};
    vecs[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1100, 1'b0};
    vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 4'b1100, 1'b0};
    vecs[16] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0};
    vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0};
    vecs[18] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0};
    vecs[19] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[20] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};

    // single request and round-robin order, against hand-derived constants
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].r, vecs[i].rq, vecs[i].ak);
      check($sformatf("vec%0d", i), {timeout, en, pending, d, c, b, a},
            {vecs[i].tmo, vecs[i].en, vecs[i].pend, vecs[i].grant});
    end

    // timeout: c held for HOLD_MAX cycles, one timeout pulse, pending[2] cleared
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    ccnt = 0;
    tcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 4'b0100, 1'b0);
      if (c && en) ccnt++;
      if (timeout) tcnt++;
    end
    check("timeout_hold_cycles", ccnt, HOLD_MAX);
    check("timeout_pulses", tcnt, 1);
    check("timeout_pend_clear", pending[2], 1'b0);

    // held level: one grant only
    cyc(1'b1, 4'b0000, 1'b0);
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'b0001, 1'b1);
      if (a && en) gcnt++;
    end
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    check("held_grants", gcnt, 1);
    check("held_pend", pending, 4'b0000);

    // set-over-clear: re-rise of b in the ack cycle keeps it pending
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    check("soc_first_grant", {en, d, c, b, a}, 5'b10010);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b1);
    check("soc_pend_kept", {en, pending}, 5'b00010);
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    check("soc_second_grant", {en, d, c, b, a}, 5'b10010);

    // reset mid-grant: drop everything, no timeout, a first afterwards
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1010, 1'b0);
    cyc(1'b0, 4'b1010, 1'b0);
    check("rmg_granting", {en, pending, d, c, b, a}, 9'b1_1010_0010);
    cyc(1'b1, 4'b0000, 1'b0);
    check("rmg_cleared", {timeout, en, pending, d, c, b, a}, 10'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    check("rmg_a_first", {en, d, c, b, a}, 5'b10001);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    // exhaustive round-robin pick
    for (int p = 0; p < 16; p++) begin
      for (int q = 0; q < 4; q++) begin
        int         e;
        logic [3:0] eoh;
        pk_pend = 4'(p);
        pk_ptr  = 2'(q);
        #1;
        e   = mpick(4'(p), q);
        eoh = '0;
        if (e >= 0) eoh[e] = 1'b1;
        check($sformatf("pick_p%0d_ptr%0d", p, q), {pk_oh, pk_idx}, {eoh, (e >= 0) ? 2'(e) : 2'd0});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
